control_unit: RTL and testbench

Multicycle control FSM for the RV64 core. It consumes the instruction register contents presented by the datapath and drives every datapath control flag: PC, ALU, register file, memory and IR load enables. It sequences fetch, decode, execute, memory and write-back states, and adds a retired-instruction counter and halt/illegal status for the bench.

---
 rtl/control_unit.sv | 190 +++++++++++++++++++
 tb/tb_control_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multicycle RV64 control FSM driving datapath flags, with retire counter and halt/illegal status
module control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic             LoadAOut,
    output logic             LoadRegA,
    output logic             LoadRegB,
    output logic             LoadMDR,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             DMemOp,
    output logic             IMemRead,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_FETCH_IR  = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXEC_R    = 4'd3;
    localparam logic [3:0] S_EXEC_I    = 4'd4;
    localparam logic [3:0] S_WB_ALU    = 4'd5;
    localparam logic [3:0] S_MEM_ADDR  = 4'd6;
    localparam logic [3:0] S_MEM_READ  = 4'd7;
    localparam logic [3:0] S_MEM_MDR   = 4'd8;
    localparam logic [3:0] S_WB_MEM    = 4'd9;
    localparam logic [3:0] S_MEM_WRITE = 4'd10;
    localparam logic [3:0] S_BRANCH    = 4'd11;
    localparam logic [3:0] S_HALT      = 4'd12;
    localparam logic [3:0] S_ERROR     = 4'd13;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f3_ok, r_ok, i_ok, ld_ok, sd_ok, beq_ok, brk, retire;
    logic [3:0] f3_op, r_op, dispatch, next_state;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    assign f3_ok  = funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    assign r_ok   = opcode == 7'b0110011 &&
                    ((funct7 == 7'b0000000 && f3_ok) || (funct7 == 7'b0100000 && funct3 == 3'b000));
    assign i_ok   = opcode == 7'b0010011 && f3_ok;
    assign ld_ok  = opcode == 7'b0000011 && funct3 == 3'b011;
    assign sd_ok  = opcode == 7'b0100011 && funct3 == 3'b011;
    assign beq_ok = opcode == 7'b1100011 && funct3 == 3'b000;
    assign brk    = instruction == 32'h0010_0073;
    assign retire = state inside {S_WB_ALU, S_WB_MEM, S_MEM_WRITE, S_BRANCH};

    // ALU function from funct3, with funct7 selecting SUB for register-register ops
    always_comb begin
        f3_op = funct3 == 3'b111 ? OP_AND :
                funct3 == 3'b110 ? OP_OR  :
                funct3 == 3'b100 ? OP_XOR :
                funct3 == 3'b010 ? OP_SLT : OP_ADD;
        r_op  = funct7 == 7'b0100000 ? OP_SUB : f3_op;
    end

    // Decode dispatch: unsupported encodings land in ERROR
    always_comb begin
        dispatch = brk    ? S_HALT     :
                   r_ok   ? S_EXEC_R   :
                   i_ok   ? S_EXEC_I   :
                   (ld_ok || sd_ok) ? S_MEM_ADDR :
                   beq_ok ? S_BRANCH   : S_ERROR;
    end

    // Next-state sequencing
    always_comb begin
        next_state = S_ERROR;
        case (state)
            S_FETCH:     next_state = S_FETCH_IR;
            S_FETCH_IR:  next_state = S_DECODE;
            S_DECODE:    next_state = dispatch;
            S_EXEC_R:    next_state = S_WB_ALU;
            S_EXEC_I:    next_state = S_WB_ALU;
            S_WB_ALU:    next_state = S_FETCH;
            S_MEM_ADDR:  next_state = opcode == 7'b0000011 ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  next_state = S_MEM_MDR;
            S_MEM_MDR:   next_state = S_WB_MEM;
            S_WB_MEM:    next_state = S_FETCH;
            S_MEM_WRITE: next_state = S_FETCH;
            S_BRANCH:    next_state = S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_ERROR;
        endcase
    end

    // State register and retired counter; every completing state returns to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            state   <= next_state;
            retired <= retired + CNT_W'(retire);
        end
    end

    // Moore output decode, gated by reset so an aborted write-back drops immediately
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = OP_ADD;
        LoadAOut    = 1'b0;
        LoadRegA    = 1'b0;
        LoadRegB    = 1'b0;
        LoadMDR     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;
        DMemOp      = 1'b0;
        IMemRead    = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    IMemRead = 1'b1;
                    ALUSrcB  = 2'd1;
                    PCWrite  = 1'b1;
                end
                S_FETCH_IR: begin
                    IMemRead = 1'b1;
                    IRWrite  = 1'b1;
                end
                S_DECODE: begin
                    LoadRegA = 1'b1;
                    LoadRegB = 1'b1;
                    ALUSrcB  = 2'd3;
                    LoadAOut = 1'b1;
                end
                S_EXEC_R: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = r_op;
                    LoadAOut = 1'b1;
                end
                S_EXEC_I: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'd2;
                    ALUOp    = f3_op;
                    LoadAOut = 1'b1;
                end
                S_WB_ALU:    RegWrite = 1'b1;
                S_MEM_ADDR: begin
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'd2;
                    LoadAOut = 1'b1;
                end
                S_MEM_MDR:   LoadMDR = 1'b1;
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEM_WRITE: DMemOp = 1'b1;
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = OP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = 1'b1;
                end
                S_HALT:      halted = 1'b1;
                S_ERROR:     illegal = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench for control_unit against a table-driven instruction model
module tb_control_unit;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   instruction = 32'h0;
    logic          PCWrite, PCWriteCond, PCSource, ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic [3:0]    ALUOp;
    logic          LoadAOut, LoadRegA, LoadRegB, LoadMDR, IRWrite, RegWrite, MemToReg, DMemOp, IMemRead;
    logic [3:0]    state;
    logic          halted, illegal;
    logic [CW-1:0] retired;

    control_unit #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .LoadAOut(LoadAOut), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .LoadMDR(LoadMDR),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MemToReg(MemToReg), .DMemOp(DMemOp),
        .IMemRead(IMemRead), .state(state), .halted(halted), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, pcwc, pcs, srca;
        logic [1:0] srcb;
        logic [3:0] op;
        logic ldaout, lda, ldb, ldmdr, irw, rw, m2r, dmem, imem, hlt, ill;
        logic [3:0] st;
        logic [CW-1:0] ret;
    } rec_t;

    rec_t          q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] cnt = '0;
    int            r_tab[logic [9:0]];
    int            i_tab[logic [2:0]];

    // Monitor: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        rec_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp,
                 LoadAOut, LoadRegA, LoadRegB, LoadMDR, IRWrite, RegWrite, MemToReg,
                 DMemOp, IMemRead, halted, illegal, state, retired};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle t=%0t state_exp=%0d instr=%h actual=%h required=%h",
                         $time, e.st, instruction, a, e);
            end
        end
    end

    // 0 R-type, 1 I-type, 2 ld, 3 sd, 4 beq, 5 ebreak, 6 illegal
    function automatic int kind(input logic [31:0] ins);
        if (ins == 32'h0010_0073) return 5;
        case (ins[6:0])
            7'b0110011: return r_tab.exists({ins[31:25], ins[14:12]}) ? 0 : 6;
            7'b0010011: return i_tab.exists(ins[14:12]) ? 1 : 6;
            7'b0000011: return ins[14:12] == 3'b011 ? 2 : 6;
            7'b0100011: return ins[14:12] == 3'b011 ? 3 : 6;
            7'b1100011: return ins[14:12] == 3'b000 ? 4 : 6;
            default:    return 6;
        endcase
    endfunction

    function automatic rec_t mk(input int s, input logic [31:0] ins);
        rec_t r = '0;
        r.st  = 4'(s);
        r.ret = cnt;
        case (s)
            0:  begin r.imem = 1; r.srcb = 1; r.pcw = 1; end
            1:  begin r.imem = 1; r.irw = 1; end
            2:  begin r.lda = 1; r.ldb = 1; r.srcb = 3; r.ldaout = 1; end
            3:  begin r.srca = 1; r.op = 4'(r_tab[{ins[31:25], ins[14:12]}]); r.ldaout = 1; end
            4:  begin r.srca = 1; r.srcb = 2; r.op = 4'(i_tab[ins[14:12]]); r.ldaout = 1; end
            5:  r.rw = 1;
            6:  begin r.srca = 1; r.srcb = 2; r.ldaout = 1; end
            8:  r.ldmdr = 1;
            9:  begin r.rw = 1; r.m2r = 1; end
            10: r.dmem = 1;
            11: begin r.srca = 1; r.op = 1; r.pcwc = 1; r.pcs = 1; end
            12: r.hlt = 1;
            13: r.ill = 1;
            default: ;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cnt = '0;
        repeat (2) begin
            q.push_back(rec_t'(0));
            step();
        end
        reset = 1'b1;
    endtask

    task automatic run(input logic [31:0] ins, input int abort_at, input int hold);
        int k;
        int path[$];
        instruction = ins;
        k = kind(ins);
        case (k)
            0:       path = '{0, 1, 2, 3, 5};
            1:       path = '{0, 1, 2, 4, 5};
            2:       path = '{0, 1, 2, 6, 7, 8, 9};
            3:       path = '{0, 1, 2, 6, 10};
            4:       path = '{0, 1, 2, 11};
            5:       path = '{0, 1, 2, 12};
            default: path = '{0, 1, 2, 13};
        endcase
        foreach (path[i]) begin
            if (path[i] == abort_at) begin
                pulse_reset();
                return;
            end
            q.push_back(mk(path[i], ins));
            step();
        end
        if (k >= 5) begin
            repeat (hold - 1) begin
                q.push_back(mk(path[3], ins));
                step();
            end
            pulse_reset();
        end else begin
            cnt = cnt + 1'b1;
        end
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [31:0] r;
        logic [6:0]  f7;
        logic [2:0]  f3;
        int          c;
        r  = $urandom();
        c  = $urandom_range(0, 9);
        f7 = $urandom_range(0, 3) == 0 ? r[31:25] : ($urandom_range(0, 1) == 1 ? 7'h20 : 7'h00);
        f3 = $urandom_range(0, 3) == 0 ? r[14:12] : 3'b011;
        case (c)
            2, 3:    return {r[31:7], 7'b0010011};
            4:       return {r[31:15], f3, r[11:7], 7'b0000011};
            5:       return {r[31:15], f3, r[11:7], 7'b0100011};
            6:       return {r[31:15], ($urandom_range(0, 3) == 0 ? r[14:12] : 3'b000), r[11:7], 7'b1100011};
            7:       return r;
            default: return {f7, r[24:7], 7'b0110011};
        endcase
    endfunction

    initial begin
        r_tab[10'b0000000_000] = 0;
        r_tab[10'b0100000_000] = 1;
        r_tab[10'b0000000_111] = 2;
        r_tab[10'b0000000_110] = 3;
        r_tab[10'b0000000_100] = 4;
        r_tab[10'b0000000_010] = 5;
        i_tab[3'b000] = 0;
        i_tab[3'b111] = 2;
        i_tab[3'b110] = 3;
        i_tab[3'b100] = 4;
        i_tab[3'b010] = 5;

        step();
        repeat (3) begin
            q.push_back(rec_t'(0));
            step();
        end
        reset = 1'b1;

        run(32'h0020_81B3, -1, 0);
        run(32'h0080_B283, -1, 0);
        run(32'h0050_B823, -1, 0);
        run(32'h0020_8463, -1, 0);
        run(32'h4020_81B3, -1, 0);
        run(32'h0010_0073, -1, 100);
        run(32'h0020_81B3, -1, 0);
        run(32'hFFFF_FFFF, -1, 3);
        run(32'h0020_81B3, -1, 0);
        run(32'h0080_B283, 9, 0);
        run(32'h0050_B823, -1, 0);

        for (int n = 0; n < 300; n++)
            run(rnd_ins(), $urandom_range(0, 19) == 0 ? int'($urandom_range(0, 11)) : -1,
                $urandom_range(1, 4));

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
